// File: rtl/bar_stack_pkg.sv
// Shared defaults and operation encoding for the branch-address stack.
package bar_stack_pkg;

   localparam int unsigned BAR_W     = 8;
   localparam int unsigned BAR_DEPTH = 8;

   typedef enum logic [2:0] {
      BOP_NONE,
      BOP_CLR,
      BOP_REPL,
      BOP_PUSH,
      BOP_POP,
      BOP_LOAD
   } bar_op_t;

endpackage

// File: rtl/bar_op_decode.sv
// Priority encoder that picks the single stack operation executed this cycle.
module bar_op_decode
   import bar_stack_pkg::*;
(
   input  logic    clr,
   input  logic    push,
   input  logic    pop,
   input  logic    we,
   output bar_op_t op
);

   always_comb begin
      op = BOP_NONE;
      if (clr) begin
         op = BOP_CLR;
      end else if (push && pop) begin
         op = BOP_REPL;
      end else if (push) begin
         op = BOP_PUSH;
      end else if (pop) begin
         op = BOP_POP;
      end else if (we) begin
         op = BOP_LOAD;
      end
   end

endmodule

// File: rtl/bar_stack.sv
// LIFO of branch/return addresses; top of stack drives the branch target.
module bar_stack
   import bar_stack_pkg::*;
#(
   parameter int unsigned W     = BAR_W,
   parameter int unsigned DEPTH = BAR_DEPTH,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic [W-1:0]  di,
   input  logic          push,
   input  logic          pop,
   input  logic          we,
   output logic [W-1:0]  dOut,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          ovf,
   output logic          unf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CountFull = CW'(DEPTH);
   localparam logic [CW-1:0] CountOne  = CW'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;
   logic          is_empty;
   logic          is_full;
   bar_op_t       op;

   bar_op_decode u_op_decode (
      .clr  (clr),
      .push (push),
      .pop  (pop),
      .we   (we),
      .op   (op)
   );

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CountFull);
   // Subtract in CW bits, narrow afterwards; only used when the stack is non-empty.
   assign top_idx  = AW'(count_q - CountOne);

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = top_idx;
      unique case (op)
         BOP_CLR: begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
         end
         BOP_REPL: begin
            wr_en = 1'b1;
            if (is_empty) begin
               wr_idx  = '0;
               count_d = CountOne;
               unf_d   = 1'b1;
            end
         end
         BOP_PUSH: begin
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               wr_en   = 1'b1;
               wr_idx  = AW'(count_q);
               count_d = count_q + CountOne;
            end
         end
         BOP_POP: begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               count_d = count_q - CountOne;
            end
         end
         BOP_LOAD: begin
            // Legacy load always lands, even into an empty stack.
            wr_en = 1'b1;
            if (is_empty) begin
               wr_idx  = '0;
               count_d = CountOne;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (wr_en) begin
            mem_q[wr_idx] <= di;
         end
      end
   end

   assign dOut  = is_empty ? '0 : mem_q[top_idx];
   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule
